// File: rtl/masked_hpc3_mul_stream_if.sv
// Bus bundle for masked_hpc3_mul_stream: operand stream, randomness stream,
// result stream and the starvation status counter.
//
// Handshake semantics (all three streams): a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holds valid and
// its payload stable until that transfer. Here, ready never depends on the
// same stream's valid. Operands and randomness move together: the block
// raises out_ready only when randomness is present and out_rand_ready only
// when operands are present, so neither stream is ever consumed alone.
interface masked_hpc3_mul_stream_if #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int NUM_LANES  = 1
);
  localparam int NUM_QUAD = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int SW       = NUM_LANES * NUM_SHARES * BIT_WIDTH;
  localparam int RW       = NUM_LANES * NUM_QUAD * BIT_WIDTH;

  logic          in_valid;
  logic          out_ready;
  logic [SW-1:0] in_a;
  logic [SW-1:0] in_b;
  logic          in_rand_valid;
  logic          out_rand_ready;
  logic [RW-1:0] in_r;
  logic [RW-1:0] in_p;
  logic          out_valid;
  logic          in_ready;
  logic [SW-1:0] out_c;
  logic [15:0]   out_starve_count;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_a, in_b, in_rand_valid, in_r, in_p, in_ready,
    input  out_ready, out_rand_ready, out_valid, out_c, out_starve_count
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, in_rand_valid, in_r, in_p, in_ready,
    output out_ready, out_rand_ready, out_valid, out_c, out_starve_count
  );
endinterface

// File: rtl/masked_hpc3_mul_stream.sv
// Multi-lane HPC3 masked multiplier with valid/ready flow control.
// Each lane computes a d-share product c = a*b:
//   stage 1 registers A_i, B_i, V_ij = B_j ^ R_ij, W_ij = A_i*R_ij ^ P_ij
//   C_i = A_i*(B_i ^ sum_j V_ij) ^ sum_j W_ij
// R and P words are shared by the pair (i,j) and (j,i); the symmetric P
// makes the P terms cancel when the output shares are recombined.
// Multiplication is GF(2^BIT_WIDTH) with a fixed irreducible polynomial
// (width 1: AND, width 4: x^4+x+1, width 8: x^8+x^4+x^3+x+1, ...).
// Supported element widths are 1..8.
module masked_hpc3_mul_stream #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int NUM_LANES  = 1,
  parameter int OUTPUT_REG = 1
) (
  input logic in_clock,
  input logic in_reset,
  masked_hpc3_mul_stream_if.slave bus
);

  function automatic int num_quad(input int d);
    return d * (d - 1) / 2;
  endfunction

  // Linear index of the unordered share pair {i,j}, i != j.
  function automatic int qindex(input int i, input int j, input int d);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  localparam int NUM_QUAD = num_quad(NUM_SHARES);
  localparam int D        = NUM_SHARES;
  localparam int W        = BIT_WIDTH;
  localparam int L        = NUM_LANES;
  localparam int SW       = L * D * W;
  localparam int PW       = L * D * D * W;

  // Low bits of the reduction polynomial (the x^W term is implicit).
  localparam int POLY = (W == 1) ? 32'h1  : (W == 2) ? 32'h3  :
                        (W == 3) ? 32'h3  : (W == 4) ? 32'h3  :
                        (W == 5) ? 32'h5  : (W == 6) ? 32'h3  :
                        (W == 7) ? 32'h3  : (W == 8) ? 32'h1B : 32'h0;

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc;
    logic [W-1:0] sh;
    logic         carry;
    acc = '0;
    sh  = x;
    for (int k = 0; k < W; k++) begin
      if (y[k]) acc = acc ^ sh;
      carry = sh[W-1];
      sh    = sh << 1;
      if (carry) sh = sh ^ W'(POLY);
    end
    return acc;
  endfunction

  // Stage-1 state: flat vectors, share (l,i) at (l*D+i)*W, pair (l,i,j) at ((l*D+i)*D+j)*W.
  logic          s1_valid_q, s1_valid_d;
  logic [SW-1:0] a_q, a_d;
  logic [SW-1:0] b_q, b_d;
  logic [PW-1:0] v_q, v_d;
  logic [PW-1:0] w_q, w_d;
  logic [15:0]   starve_q, starve_d;

  logic          s1_adv;
  logic          s1_free;
  logic          fire;
  logic [SW-1:0] c_comb;
  logic [W-1:0]  v_sum;
  logic [W-1:0]  w_sum;

  assign s1_free            = !s1_valid_q || s1_adv;
  assign fire               = bus.in_valid && bus.in_rand_valid && s1_free;
  assign bus.out_ready      = s1_free && bus.in_rand_valid;
  assign bus.out_rand_ready = s1_free && bus.in_valid;
  assign bus.out_starve_count = starve_q;

  // Stage-1 next state: load fresh shares only on fire, otherwise hold.
  // V/W are formed from one share of one operand plus randomness only.
  always_comb begin
    s1_valid_d = fire || (s1_valid_q && !s1_adv);
    a_d = a_q;
    b_d = b_q;
    v_d = v_q;
    w_d = w_q;
    if (fire) begin
      a_d = bus.in_a;
      b_d = bus.in_b;
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < D; i++) begin
          for (int j = 0; j < D; j++) begin
            if (i == j) begin
              v_d[((l*D+i)*D+j)*W +: W] = '0;
              w_d[((l*D+i)*D+j)*W +: W] = '0;
            end else begin
              v_d[((l*D+i)*D+j)*W +: W] =
                bus.in_b[(l*D+j)*W +: W] ^ bus.in_r[(l*NUM_QUAD+qindex(i, j, D))*W +: W];
              w_d[((l*D+i)*D+j)*W +: W] =
                gf_mul(bus.in_a[(l*D+i)*W +: W],
                       bus.in_r[(l*NUM_QUAD+qindex(i, j, D))*W +: W]) ^
                bus.in_p[(l*NUM_QUAD+qindex(i, j, D))*W +: W];
            end
          end
        end
      end
    end
  end

  // Output share compression from the stage-1 registers (diagonal V/W are zero).
  always_comb begin
    c_comb = '0;
    v_sum  = '0;
    w_sum  = '0;
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < D; i++) begin
        v_sum = b_q[(l*D+i)*W +: W];
        w_sum = '0;
        for (int j = 0; j < D; j++) begin
          v_sum = v_sum ^ v_q[((l*D+i)*D+j)*W +: W];
          w_sum = w_sum ^ w_q[((l*D+i)*D+j)*W +: W];
        end
        c_comb[(l*D+i)*W +: W] = gf_mul(a_q[(l*D+i)*W +: W], v_sum) ^ w_sum;
      end
    end
  end

  // Starvation counter: operands waiting, room available, randomness absent.
  always_comb begin
    starve_d = starve_q;
    if (bus.in_valid && s1_free && !bus.in_rand_valid && (starve_q != 16'hFFFF)) begin
      starve_d = starve_q + 16'd1;
    end
  end

  // Stage-1 registers and starvation counter.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      v_q        <= '0;
      w_q        <= '0;
      starve_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      v_q        <= v_d;
      w_q        <= w_d;
      starve_q   <= starve_d;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic          s2_valid_q, s2_valid_d;
      logic [SW-1:0] c_q, c_d;

      assign s1_adv = s1_valid_q && (!s2_valid_q || bus.in_ready);

      // Stage-2 next state: capture C when stage 1 advances, hold while stalled.
      always_comb begin
        s2_valid_d = s1_adv || (s2_valid_q && !bus.in_ready);
        c_d        = s1_adv ? c_comb : c_q;
      end

      // Stage-2 result register.
      always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
          s2_valid_q <= 1'b0;
          c_q        <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          c_q        <= c_d;
        end
      end

      assign bus.out_valid = s2_valid_q;
      assign bus.out_c     = c_q;
    end else begin : g_comb
      assign s1_adv        = s1_valid_q && bus.in_ready;
      assign bus.out_valid = s1_valid_q;
      assign bus.out_c     = c_comb;
    end
  endgenerate

endmodule

// File: tb/tb_masked_hpc3_mul_stream.sv
// Bench for masked_hpc3_mul_stream: a narrow registered instance
// (d=2, w=1, one lane) and a wide combinational-output instance
// (d=3, w=4, two lanes, GF(2^4) with x^4+x+1), sharing clock and reset.
module tb_masked_hpc3_mul_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_hpc3_mul_stream_if #(.NUM_SHARES(2), .BIT_WIDTH(1), .NUM_LANES(1)) ia ();
  masked_hpc3_mul_stream_if #(.NUM_SHARES(3), .BIT_WIDTH(4), .NUM_LANES(2)) ib ();

  masked_hpc3_mul_stream #(.NUM_SHARES(2), .BIT_WIDTH(1), .NUM_LANES(1), .OUTPUT_REG(1)) dut_a (
    .in_clock (clk),
    .in_reset (rst_n),
    .bus      (ia.slave)
  );

  masked_hpc3_mul_stream #(.NUM_SHARES(3), .BIT_WIDTH(4), .NUM_LANES(2), .OUTPUT_REG(0)) dut_b (
    .in_clock (clk),
    .in_reset (rst_n),
    .bus      (ib.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];     // expected unmasked product
  logic [1:0] exp_sh_q[$];  // expected output share pair
  logic       mon_a = 1'b0;
  logic [1:0] mon_sh;
  logic [0:0] mon_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // For d=2: C_0 = A_0*(B_0^B_1) ^ P, C_1 = A_1*(B_0^B_1) ^ P.
  function automatic logic [1:0] shares_a(input logic [1:0] a, input logic [1:0] b, input logic p);
    logic bb;
    bb = b[0] ^ b[1];
    return {(a[1] & bb) ^ p, (a[0] & bb) ^ p};
  endfunction

  // Retire results from instance A in order.
  always @(negedge clk) begin
    if (mon_a && ia.out_valid && ia.in_ready) begin
      if (exp_q.size() == 0) begin
        check("a_unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_sh = exp_sh_q.pop_front();
        mon_p  = exp_q.pop_front();
        check("a_shares", 64'(ia.out_c), 64'(mon_sh));
        check("a_xor", 64'(^ia.out_c), 64'(mon_p));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [1:0] a, input logic [1:0] b, input logic r, input logic p);
    ia.in_a = a;
    ia.in_b = b;
    ia.in_r = r;
    ia.in_p = p;
  endtask

  // Offer one operation (operands + randomness) and push its expectation
  // once acceptance is certain. Entered and left at posedge+1.
  task automatic send_a(input logic [1:0] a, input logic [1:0] b, input logic r, input logic p);
    int n;
    n = 0;
    set_a(a, b, r, p);
    ia.in_valid      = 1'b1;
    ia.in_rand_valid = 1'b1;
    #1;
    while (ia.out_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) check("a_accept_timeout", 64'd0, 64'd1);
    exp_q.push_back((a[0] ^ a[1]) & (b[0] ^ b[1]));
    exp_sh_q.push_back(shares_a(a, b, p));
    @(posedge clk);
    #1;
    ia.in_valid      = 1'b0;
    ia.in_rand_valid = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    repeat (6) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [3:0] lane_xor_b(input logic [23:0] c, input int l);
    logic [3:0] x;
    x = '0;
    for (int i = 0; i < 3; i++) x = x ^ c[(l*3+i)*4 +: 4];
    return x;
  endfunction

  // GF(2^4) mod x^4+x+1 products, worked by hand.
  logic [3:0] bv_a [0:7] = '{4'h3, 4'h8, 4'hF, 4'h5, 4'h1, 4'h9, 4'h4, 4'hC};
  logic [3:0] bv_b [0:7] = '{4'h7, 4'h2, 4'hF, 4'h0, 4'hB, 4'h6, 4'h4, 4'hA};
  logic [3:0] bv_c [0:7] = '{4'h9, 4'h3, 4'hA, 4'h0, 4'hB, 4'h3, 4'h3, 4'h1};

  task automatic drive_b_lane(input int l, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s0, s1;
    s0 = 4'($urandom_range(0, 15));
    s1 = 4'($urandom_range(0, 15));
    ib.in_a[(l*3+0)*4 +: 4] = s0;
    ib.in_a[(l*3+1)*4 +: 4] = s1;
    ib.in_a[(l*3+2)*4 +: 4] = a ^ s0 ^ s1;
    s0 = 4'($urandom_range(0, 15));
    s1 = 4'($urandom_range(0, 15));
    ib.in_b[(l*3+0)*4 +: 4] = s0;
    ib.in_b[(l*3+1)*4 +: 4] = s1;
    ib.in_b[(l*3+2)*4 +: 4] = b ^ s0 ^ s1;
  endtask

  // Watchdog.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    ia.in_valid = 1'b0; ia.in_rand_valid = 1'b0; ia.in_ready = 1'b0;
    ia.in_a = '0; ia.in_b = '0; ia.in_r = '0; ia.in_p = '0;
    ib.in_valid = 1'b0; ib.in_rand_valid = 1'b0; ib.in_ready = 1'b1;
    ib.in_a = '0; ib.in_b = '0; ib.in_r = '0; ib.in_p = '0;

    // Reset state.
    repeat (2) tick();
    check("rst_a_valid", 64'(ia.out_valid), 64'd0);
    check("rst_a_c", 64'(ia.out_c), 64'd0);
    check("rst_a_starve", 64'(ia.out_starve_count), 64'd0);
    check("rst_b_c", 64'(ib.out_c), 64'd0);
    check("rst_a_ready_idle", 64'(ia.out_ready), 64'd0);
    ia.in_rand_valid = 1'b1;
    #1;
    check("rst_a_ready_rand", 64'(ia.out_ready), 64'd1);
    check("rst_a_rready_idle", 64'(ia.out_rand_ready), 64'd0);
    ia.in_rand_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1a: latency of 2 with OUTPUT_REG=1.
    ia.in_ready = 1'b1;
    set_a(2'b01, 2'b10, 1'b1, 1'b0);
    ia.in_valid = 1'b1;
    ia.in_rand_valid = 1'b1;
    #1;
    check("lat_fire_ready", 64'(ia.out_ready), 64'd1);
    tick();
    ia.in_valid = 1'b0;
    ia.in_rand_valid = 1'b0;
    #1;
    check("lat_cycle1_valid", 64'(ia.out_valid), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(ia.out_valid), 64'd1);
    check("lat_cycle2_c", 64'(ia.out_c), 64'(shares_a(2'b01, 2'b10, 1'b0)));
    check("lat_cycle2_xor", 64'(^ia.out_c), 64'd1);
    tick();
    check("lat_retired", 64'(ia.out_valid), 64'd0);

    // Test 1b: all share combinations x r x p, streaming.
    mon_a = 1'b1;
    for (int k = 0; k < 64; k++) begin
      logic [5:0] kv;
      kv = k[5:0];
      send_a(kv[1:0], kv[3:2], kv[4], kv[5]);
    end
    drain_a("t1_drain");

    // Test 2: backpressure with both stages full.
    ia.in_ready = 1'b0;
    set_a(2'b01, 2'b01, 1'b0, 1'b1);
    ia.in_valid = 1'b1; ia.in_rand_valid = 1'b1;
    #1;
    check("bp_ready_op1", 64'(ia.out_ready), 64'd1);
    exp_q.push_back(1'b1); exp_sh_q.push_back(shares_a(2'b01, 2'b01, 1'b1));
    tick();
    set_a(2'b11, 2'b01, 1'b1, 1'b0);
    #1;
    check("bp_ready_op2", 64'(ia.out_ready), 64'd1);
    exp_q.push_back(1'b0); exp_sh_q.push_back(shares_a(2'b11, 2'b01, 1'b0));
    tick();
    set_a(2'b10, 2'b10, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      #1;
      check("bp_full_ready", 64'(ia.out_ready), 64'd0);
      check("bp_full_valid", 64'(ia.out_valid), 64'd1);
      check("bp_hold_c", 64'(ia.out_c), 64'(shares_a(2'b01, 2'b01, 1'b1)));
      if (s < 3) begin
        @(posedge clk);
        #1;
      end
    end
    ia.in_ready = 1'b1;
    #1;
    check("bp_drain_accept", 64'(ia.out_ready), 64'd1);
    exp_q.push_back(1'b1); exp_sh_q.push_back(shares_a(2'b10, 2'b10, 1'b0));
    tick();
    ia.in_valid = 1'b0; ia.in_rand_valid = 1'b0;
    drain_a("bp_drain");

    // Test 3: randomness starvation for 5 cycles.
    check("starve_start", 64'(ia.out_starve_count), 64'd0);
    set_a(2'b10, 2'b11, 1'b1, 1'b1);
    ia.in_valid = 1'b1; ia.in_rand_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("starve_rready", 64'(ia.out_rand_ready), 64'd1);
      check("starve_no_ready", 64'(ia.out_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    check("starve_count5", 64'(ia.out_starve_count), 64'd5);
    ia.in_rand_valid = 1'b1;
    #1;
    check("starve_accept", 64'(ia.out_ready), 64'd1);
    exp_q.push_back(1'b0); exp_sh_q.push_back(shares_a(2'b10, 2'b11, 1'b1));
    tick();
    ia.in_valid = 1'b0; ia.in_rand_valid = 1'b0;
    drain_a("starve_drain");
    check("starve_count_hold", 64'(ia.out_starve_count), 64'd5);

    // Test 5: asynchronous reset with the pipe full.
    ia.in_ready = 1'b0;
    send_a(2'b01, 2'b11, 1'b0, 1'b0);
    send_a(2'b11, 2'b10, 1'b1, 1'b1);
    #1;
    check("rst_pipe_full", 64'(ia.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(ia.out_valid), 64'd0);
    check("rst_mid_c", 64'(ia.out_c), 64'd0);
    check("rst_mid_starve", 64'(ia.out_starve_count), 64'd0);
    ia.in_rand_valid = 1'b1;
    #1;
    check("rst_mid_ready", 64'(ia.out_ready), 64'd1);
    ia.in_rand_valid = 1'b0;
    exp_q.delete();
    exp_sh_q.delete();
    tick();
    rst_n = 1'b1;
    ia.in_ready = 1'b1;
    tick();
    send_a(2'b10, 2'b01, 1'b1, 1'b0);
    drain_a("rst_after_drain");

    // Test 4: wide instance, latency 1, two independent lanes.
    check("b_idle_valid", 64'(ib.out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      drive_b_lane(0, bv_a[2*k], bv_b[2*k]);
      drive_b_lane(1, bv_a[2*k+1], bv_b[2*k+1]);
      ib.in_r = 24'($urandom);
      ib.in_p = 24'($urandom);
      ib.in_valid = 1'b1;
      ib.in_rand_valid = 1'b1;
      #1;
      check("b_ready", 64'(ib.out_ready), 64'd1);
      @(posedge clk);
      #1;
      check("b_valid_lat1", 64'(ib.out_valid), 64'd1);
      check("b_lane0_prod", 64'(lane_xor_b(ib.out_c, 0)), 64'(bv_c[2*k]));
      check("b_lane1_prod", 64'(lane_xor_b(ib.out_c, 1)), 64'(bv_c[2*k+1]));
    end
    ib.in_valid = 1'b0;
    ib.in_rand_valid = 1'b0;
    tick();
    check("b_drained", 64'(ib.out_valid), 64'd0);

    // Test 6: starvation counter saturation.
    check("sat_start", 64'(ia.out_starve_count), 64'd0);
    ia.in_valid = 1'b1;
    ia.in_rand_valid = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 64'(ia.out_starve_count), 64'hFFFE);
    tick();
    check("sat_ffff", 64'(ia.out_starve_count), 64'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    check("sat_stays", 64'(ia.out_starve_count), 64'hFFFF);
    ia.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/masked_hpc3_mul_stream.md
Name: masked_hpc3_mul_stream

Overview:
Multi-lane, handshaked successor to the single-cycle HPC3 masked multiplier.
- Each lane computes a d-share masked product c = a*b using the HPC3 gadget: V_ij = B_j ^ R_ij and W_ij = A_i*R_ij ^ P_ij are registered, then C_i = A_i*(B_i ^ sum_j V_ij) ^ sum_j W_ij.
- Adds valid/ready flow control on data, a separate randomness handshake, an optional output register and a randomness-starvation counter.
- Sits between the S-box datapath stages and the randomness distribution network.

Parameters:
NUM_SHARES, 2, number of Boolean shares d (>=2).
BIT_WIDTH, 1, element width; multiplication is generic_mul of this width.
NUM_LANES, 1, number of independent multipliers sharing one handshake.
OUTPUT_REG, 1, 1 = register C_i (latency 2); 0 = C_i combinational from stage 1 (latency 1).
NUM_QUAD (local), num_quad(NUM_SHARES), randomness words per lane per operand (d(d-1)/2).

Ports:
in_clock  input  1  clock, rising edge.
in_reset  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream operand valid.
out_ready  output  1  block accepts operands this cycle.
in_a  input  NUM_LANES*NUM_SHARES*BIT_WIDTH  shares of a; lane l, share i at [l][i].
in_b  input  NUM_LANES*NUM_SHARES*BIT_WIDTH  shares of b.
in_rand_valid  input  1  fresh randomness present.
out_rand_ready  output  1  randomness consumed this cycle.
in_r  input  NUM_LANES*NUM_QUAD*BIT_WIDTH  R words; lane l, pair (i,j) at [l][qindex(i,j,NUM_SHARES)].
in_p  input  NUM_LANES*NUM_QUAD*BIT_WIDTH  P words, same indexing.
out_valid  output  1  result valid.
in_ready  input  1  downstream accepts result.
out_c  output  NUM_LANES*NUM_SHARES*BIT_WIDTH  result shares.
out_starve_count  output  16  saturating count of randomness-starved cycles.

Behaviour:
- Reset (in_reset=0, async): clear all valid flags, data registers and counter. Result: out_valid=0, out_c=0, out_starve_count=0. out_ready and out_rand_ready are then driven purely by in_rand_valid / in_valid.
- Stage 1 register bank: A_i, B_i, all V_ij and W_ij for every lane, plus s1_valid. Stage 2 (OUTPUT_REG=1 only) holds C_i and s2_valid.
- Advance conditions:
  - s2_free = !s2_valid | in_ready.
  - s1_adv = s1_valid & (OUTPUT_REG ? s2_free : in_ready).
  - s1_free = !s1_valid | s1_adv.
- Handshake:
  - fire = in_valid & in_rand_valid & s1_free.
  - out_ready = s1_free & in_rand_valid.
  - out_rand_ready = s1_free & in_valid.
  - Operands and randomness are consumed atomically on fire; neither is consumed alone.
  - No combinational path from in_valid to out_ready or from in_rand_valid to out_rand_ready.
- Register loading:
  - Stage 1 loads only on fire; otherwise it holds its previous contents (enable, never a mux to 0). This prevents combining stale and fresh shares.
  - s1_valid <= fire | (s1_valid & !s1_adv).
  - With OUTPUT_REG=1: stage 2 loads C on s1_adv; s2_valid <= s1_adv | (s2_valid & !in_ready).
- Outputs:
  - out_valid = OUTPUT_REG ? s2_valid : s1_valid.
  - out_c holds stable while out_valid=1 and in_ready=0.
- Throughput and latency: one operation per cycle when in_ready=1 and randomness is continuous. Latency from fire to out_valid is 1 cycle (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1).
- Simultaneous events: a full pipe draining (in_ready=1) accepts a new fire in the same cycle. With a full pipe and in_ready=0, out_ready=0.
- Share isolation: no logic combines shares i and j of a lane before the stage-1 register, except through R-blinded V_ij and P-blinded W_ij.
- Starvation counter: out_starve_count increments when in_valid & s1_free & !in_rand_valid, and saturates at 16'hFFFF.
- Lanes are fully independent in data but share all control.

Test Plan:
1. d=2, w=1, OUTPUT_REG=1.
   Stimulus: a=(1,0), b=(0,1), r=1, p=0, rand valid, in_ready=1.
   Response: out_valid rises 2 cycles after fire; out_c[0]^out_c[1]=1. Repeat over all 16 share combinations × r,p ∈ {0,1}: XOR of out_c equals (a0^a1)&(b0^b1).
2. Backpressure, OUTPUT_REG=1.
   Stimulus: 3 back-to-back ops, in_ready=0 for 4 cycles, then in_ready=1.
   Response: out_ready=0 once both stages are full; results emerge in order, none lost or duplicated; out_c stable while stalled.
3. Starvation.
   Stimulus: in_valid=1, in_rand_valid=0 for 5 cycles, then 1.
   Response: no fire, out_rand_ready=1 throughout, out_starve_count=5, op accepted on cycle 6.
4. Wide configuration: d=3, w=4, NUM_LANES=2, OUTPUT_REG=0.
   Stimulus: random shares and randomness.
   Response: latency 1; each lane's XOR of shares equals generic_mul(a,b) of the unmasked values.
5. Reset.
   Stimulus: assert in_reset=0 mid-stream with the pipe full.
   Response: out_valid=0 and out_c=0 immediately (asynchronous); counter 0; after release the first fire yields the correct result.
6. Counter saturation.
   Stimulus: force starvation for 70000 cycles.
   Response: out_starve_count=16'hFFFF and stays there.
